// File: rtl/ldl_p2ram_pkg.sv
`default_nettype none
// ============================================================================
// ldl_p2ram_pkg : shared types for the dual-port RAM burst reader.
// Revision 1.0
// ============================================================================
package ldl_p2ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/ldl_skid_buf2.sv
`default_nettype none
// ============================================================================
// ldl_skid_buf2 : two-entry FIFO with a valid/ready head and an occupancy count.
// Revision 1.0
// ============================================================================
module ldl_skid_buf2
    import ldl_p2ram_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [BUF_DEPTH];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = o_valid && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldl_p2ram_burst_reader.sv
`default_nettype none
// ============================================================================
// ldl_p2ram_burst_reader : burst read controller for the registered-read RAM,
// presenting words as a valid/ready stream. Option: LDL_P2RAM_RD_WRAP_EN.
// Revision 1.0
// ============================================================================
module ldl_p2ram_burst_reader
    import ldl_p2ram_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          trunc
);

    rd_state_e     r_state;
    rd_state_e     w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_ra;
    logic [AW:0]   r_remaining;
    logic          r_re_d1;
    logic          r_last_d1;
    logic          w_accept;
    logic          w_issue;
    logic          w_pop;
    logic          w_room;
    logic [2:0]    w_inflight;
    logic [1:0]    w_occ;
    logic [AW-1:0] w_addr_nxt;
    logic [AW:0]   w_len_full;
    logic [AW:0]   w_len_eff;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_len_full = {1'b0, cmd_len} + (AW+1)'(1);
    // Words still owed to the buffer after this edge, including last cycle's issue.
    assign w_inflight = {1'b0, w_occ} + {2'b0, r_re_d1} - {2'b0, w_pop};
    assign w_room     = (w_inflight < 3'(BUF_DEPTH));

`ifdef LDL_P2RAM_RD_WRAP_EN
    assign w_len_eff  = w_len_full;
    assign w_addr_nxt = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
    assign trunc      = 1'b0;
`else
    logic [AW:0] w_span;
    logic        w_trunc_cmd;
    logic        r_trunc;

    assign w_span      = (AW+1)'(DEPTH) - {1'b0, cmd_addr};
    assign w_trunc_cmd = (w_len_full > w_span);
    assign w_len_eff   = w_trunc_cmd ? w_span : w_len_full;
    assign w_addr_nxt  = r_addr + AW'(1);
    assign trunc       = r_trunc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= w_accept && w_trunc_cmd;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = (r_remaining != '0) && w_room;
                if (w_issue && (r_remaining == (AW+1)'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && out_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_ra        <= '0;
            r_remaining <= '0;
            r_re_d1     <= 1'b0;
            r_last_d1   <= 1'b0;
        end else begin
            r_re_d1   <= w_issue;
            r_last_d1 <= w_issue && (r_remaining == (AW+1)'(1));
            if (w_accept) begin
                r_addr      <= cmd_addr;
                r_remaining <= w_len_eff;
            end else if (w_issue) begin
                r_ra        <= r_addr;
                r_addr      <= w_addr_nxt;
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

    assign ram_re = w_issue;
    assign ram_ra = w_issue ? r_addr : r_ra;
    assign busy   = (r_state != IDLE);

    ldl_skid_buf2 #(
        .W (DW + 1)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_re_d1),
        .i_data  ({r_last_d1, ram_dout}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  ({out_last, out_data}),
        .o_count (w_occ)
    );

endmodule
`default_nettype wire

// File: tb/tb_ldl_p2ram_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_ldl_p2ram_burst_reader : directed self-checking bench for the burst reader.
// Revision 1.0
// ============================================================================
module tb_ldl_p2ram_burst_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          trunc;

    logic [DW-1:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    logic          rec_re   [64];
    logic [AW-1:0] rec_ra   [64];
    logic          rec_ov   [64];
    logic [DW-1:0] rec_od   [64];
    logic          rec_ol   [64];
    logic          rec_rdy  [64];
    logic          rec_cr   [64];
    logic          rec_busy [64];
    logic          rec_tr   [64];
    logic [DW-1:0] hs_data  [16];
    logic          hs_last  [16];
    int            hs_k     [16];
    int            hs_n;
    logic          acc_seen;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    end

    always @(posedge clk) begin
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    ldl_p2ram_burst_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_re    (ram_re),
        .ram_ra    (ram_ra),
        .ram_dout  (ram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .trunc     (trunc)
    );

    // Presents one command in cycle T; returns at the start of T+1.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        acc_seen = cmd_ready;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Records cycles T+1..T+n; mode 1 toggles out_ready every two cycles.
    task automatic record(input int n, input int mode, input int cv_until);
        hs_n = 0;
        for (int k = 1; k <= n; k++) begin
            out_ready = (mode == 0) ? 1'b1 : ((k / 2) % 2 == 0);
            cmd_valid = (k <= cv_until);
            @(negedge clk);
            rec_re[k]   = ram_re;
            rec_ra[k]   = ram_ra;
            rec_ov[k]   = out_valid;
            rec_od[k]   = out_data;
            rec_ol[k]   = out_last;
            rec_rdy[k]  = out_ready;
            rec_cr[k]   = cmd_ready;
            rec_busy[k] = busy;
            rec_tr[k]   = trunc;
            if (out_valid && out_ready && hs_n < 16) begin
                hs_data[hs_n] = out_data;
                hs_last[hs_n] = out_last;
                hs_k[hs_n]    = k;
                hs_n++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, ram_re, out_valid, out_last, busy, trunc} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got cr/re/ov/ol/busy/tr=%b expected 000000",
                     {cmd_ready, ram_re, out_valid, out_last, busy, trunc});
        end
        n_tests++;
        if ({ram_ra, out_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_data: got ra=%h data=%h expected 0 0", ram_ra, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        send_cmd(4'd3, 4'd0);
        record(6, 0, 0);
        n_tests++;
        if (acc_seen !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", acc_seen); end
        n_tests++;
        if ({rec_re[1], rec_ra[1]} !== {1'b1, 4'd3}) begin
            n_fail++; $display("FAIL single_issue: got re=%b ra=%0d expected re=1 ra=3", rec_re[1], rec_ra[1]);
        end
        n_tests++;
        if ({rec_re[2], rec_re[3]} !== 2'b00) begin
            n_fail++; $display("FAIL single_extra_re: got %b%b expected 00", rec_re[2], rec_re[3]);
        end
        n_tests++;
        if (rec_ov[2] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", rec_ov[2]); end
        n_tests++;
        if ({rec_ov[3], rec_ol[3], rec_od[3]} !== {1'b1, 1'b1, 8'h13}) begin
            n_fail++; $display("FAIL single_word: got v=%b l=%b d=%h expected v=1 l=1 d=13",
                               rec_ov[3], rec_ol[3], rec_od[3]);
        end
        n_tests++;
        if ({rec_cr[3], rec_cr[4], rec_busy[1], rec_busy[4]} !== 4'b0110) begin
            n_fail++; $display("FAIL single_ready_busy: got cr3/cr4/b1/b4=%b%b%b%b expected 0110",
                               rec_cr[3], rec_cr[4], rec_busy[1], rec_busy[4]);
        end
    endtask

    task automatic test_stream;
        send_cmd(4'd0, 4'd7);
        record(14, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            n_tests++;
            if ({rec_re[k], rec_ra[k]} !== {1'b1, 4'(k - 1)}) begin
                n_fail++; $display("FAIL stream_issue[%0d]: got re=%b ra=%0d expected re=1 ra=%0d",
                                   k, rec_re[k], rec_ra[k], k - 1);
            end
        end
        n_tests++;
        if (rec_re[9] !== 1'b0) begin n_fail++; $display("FAIL stream_re_after: got %b expected 0", rec_re[9]); end
        n_tests++;
        if (hs_n !== 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", hs_n); end
        for (int i = 0; i < 8 && i < hs_n; i++) begin
            n_tests++;
            if (hs_k[i] !== i + 3 || hs_data[i] !== 8'(16 + i) || hs_last[i] !== (i == 7)) begin
                n_fail++; $display("FAIL stream_word[%0d]: got cyc=%0d d=%h l=%b expected cyc=%0d d=%h l=%b",
                                   i, hs_k[i], hs_data[i], hs_last[i], i + 3, 8'(16 + i), (i == 7));
            end
        end
        n_tests++;
        if ({rec_cr[10], rec_cr[11]} !== 2'b01) begin
            n_fail++; $display("FAIL stream_ready_after: got %b%b expected 01", rec_cr[10], rec_cr[11]);
        end
    endtask

    task automatic test_backpressure;
        int issued, popped, max_out;
        issued = 0; popped = 0; max_out = 0;
        send_cmd(4'd0, 4'd7);
        record(40, 1, 0);
        n_tests++;
        if (hs_n !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", hs_n); end
        for (int i = 0; i < 8 && i < hs_n; i++) begin
            n_tests++;
            if (hs_data[i] !== 8'(16 + i) || hs_last[i] !== (i == 7)) begin
                n_fail++; $display("FAIL bp_word[%0d]: got d=%h l=%b expected d=%h l=%b",
                                   i, hs_data[i], hs_last[i], 8'(16 + i), (i == 7));
            end
        end
        for (int k = 1; k <= 40; k++) begin
            issued += int'(rec_re[k]);
            popped += int'(rec_ov[k] && rec_rdy[k]);
            if (issued - popped > max_out) max_out = issued - popped;
        end
        n_tests++;
        if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected <=2", max_out); end
        n_tests++;
        if (issued !== 8) begin n_fail++; $display("FAIL bp_issues: got %0d expected 8", issued); end
        for (int k = 2; k <= 40; k++) begin
            if (rec_ov[k-1] && !rec_rdy[k-1]) begin
                n_tests++;
                if (!rec_ov[k] || rec_od[k] !== rec_od[k-1] || rec_ol[k] !== rec_ol[k-1]) begin
                    n_fail++; $display("FAIL bp_stable[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                       k, rec_ov[k], rec_od[k], rec_ol[k], rec_od[k-1], rec_ol[k-1]);
                end
            end
        end
        n_tests++;
        if (rec_busy[40] !== 1'b0) begin n_fail++; $display("FAIL bp_idle_end: got busy=%b expected 0", rec_busy[40]); end
    endtask

    task automatic test_edge;
        send_cmd(4'd8, 4'd3);
        record(10, 0, 0);
`ifdef LDL_P2RAM_RD_WRAP_EN
        begin
            logic [AW-1:0] exp_ra [4];
            logic [DW-1:0] exp_d  [4];
            int            tr_hits;
            exp_ra[0] = 4'd8; exp_ra[1] = 4'd9; exp_ra[2] = 4'd0; exp_ra[3] = 4'd1;
            exp_d[0] = 8'h18; exp_d[1] = 8'h19; exp_d[2] = 8'h10; exp_d[3] = 8'h11;
            for (int k = 1; k <= 4; k++) begin
                n_tests++;
                if ({rec_re[k], rec_ra[k]} !== {1'b1, exp_ra[k-1]}) begin
                    n_fail++; $display("FAIL wrap_issue[%0d]: got re=%b ra=%0d expected re=1 ra=%0d",
                                       k, rec_re[k], rec_ra[k], exp_ra[k-1]);
                end
            end
            n_tests++;
            if (hs_n !== 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", hs_n); end
            for (int i = 0; i < 4 && i < hs_n; i++) begin
                n_tests++;
                if (hs_data[i] !== exp_d[i] || hs_last[i] !== (i == 3)) begin
                    n_fail++; $display("FAIL wrap_word[%0d]: got d=%h l=%b expected d=%h l=%b",
                                       i, hs_data[i], hs_last[i], exp_d[i], (i == 3));
                end
            end
            tr_hits = 0;
            for (int k = 1; k <= 10; k++) tr_hits += int'(rec_tr[k]);
            n_tests++;
            if (tr_hits !== 0) begin n_fail++; $display("FAIL wrap_trunc: got %0d pulses expected 0", tr_hits); end
        end
`else
        n_tests++;
        if ({rec_tr[1], rec_tr[2]} !== 2'b10) begin
            n_fail++; $display("FAIL trunc_pulse: got %b%b expected 10", rec_tr[1], rec_tr[2]);
        end
        n_tests++;
        if ({rec_re[1], rec_ra[1], rec_re[2], rec_ra[2]} !== {1'b1, 4'd8, 1'b1, 4'd9}) begin
            n_fail++; $display("FAIL trunc_issue: got re/ra=%b/%0d %b/%0d expected 1/8 1/9",
                               rec_re[1], rec_ra[1], rec_re[2], rec_ra[2]);
        end
        n_tests++;
        if ({rec_re[3], rec_ra[3]} !== {1'b0, 4'd9}) begin
            n_fail++; $display("FAIL trunc_hold: got re=%b ra=%0d expected re=0 ra=9", rec_re[3], rec_ra[3]);
        end
        n_tests++;
        if (hs_n !== 2) begin n_fail++; $display("FAIL trunc_count: got %0d expected 2", hs_n); end
        n_tests++;
        if ({hs_data[0], hs_last[0], hs_data[1], hs_last[1]} !== {8'h18, 1'b0, 8'h19, 1'b1}) begin
            n_fail++; $display("FAIL trunc_words: got %h/%b %h/%b expected 18/0 19/1",
                               hs_data[0], hs_last[0], hs_data[1], hs_last[1]);
        end
        n_tests++;
        if (rec_cr[5] !== 1'b1) begin n_fail++; $display("FAIL trunc_ready_after: got %b expected 1", rec_cr[5]); end
`endif
    endtask

    task automatic test_reset_mid;
        send_cmd(4'd0, 4'd7);
        record(4, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, ram_re, out_valid, out_last, busy, trunc, ram_ra, out_data} !== 18'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got cr=%b re=%b v=%b l=%b b=%b tr=%b ra=%h d=%h expected all 0",
                               cmd_ready, ram_re, out_valid, out_last, busy, trunc, ram_ra, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL midrst_release: got cr=%b v=%b expected cr=1 v=0", cmd_ready, out_valid);
        end
        @(posedge clk); #1;
        send_cmd(4'd2, 4'd1);
        record(8, 0, 0);
        n_tests++;
        if ({rec_ov[1], rec_ov[2]} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_stale: got %b%b expected 00", rec_ov[1], rec_ov[2]);
        end
        n_tests++;
        if (hs_n !== 2 || {hs_data[0], hs_last[0], hs_data[1], hs_last[1]} !== {8'h12, 1'b0, 8'h13, 1'b1}) begin
            n_fail++; $display("FAIL midrst_words: got n=%0d %h/%b %h/%b expected n=2 12/0 13/1",
                               hs_n, hs_data[0], hs_last[0], hs_data[1], hs_last[1]);
        end
    endtask

    task automatic test_back_to_back;
        send_cmd(4'd0, 4'd2);
        cmd_addr = 4'd5;
        cmd_len  = 4'd1;
        record(14, 0, 6);
        for (int k = 1; k <= 5; k++) begin
            n_tests++;
            if (rec_cr[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_early[%0d]: got %b expected 0", k, rec_cr[k]); end
        end
        n_tests++;
        if (rec_cr[6] !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", rec_cr[6]); end
        n_tests++;
        if ({rec_busy[5], rec_busy[6], rec_busy[7]} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_busy_gap: got %b%b%b expected 101", rec_busy[5], rec_busy[6], rec_busy[7]);
        end
        n_tests++;
        if (hs_n !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", hs_n); end
        n_tests++;
        if (hs_k[2] !== 5 || hs_data[2] !== 8'h12 || hs_last[2] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_last: got cyc=%0d d=%h l=%b expected cyc=5 d=12 l=1",
                               hs_k[2], hs_data[2], hs_last[2]);
        end
        n_tests++;
        if (hs_k[3] !== 9 || hs_k[4] !== 10 ||
            {hs_data[3], hs_last[3], hs_data[4], hs_last[4]} !== {8'h15, 1'b0, 8'h16, 1'b1}) begin
            n_fail++; $display("FAIL b2b_second: got %0d:%h/%b %0d:%h/%b expected 9:15/0 10:16/1",
                               hs_k[3], hs_data[3], hs_last[3], hs_k[4], hs_data[4], hs_last[4]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_edge();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
